// File: rtl/proc_pkg.sv
// Shared processor types: control-bit bundle, opcodes and the ID/EX register payload.
package proc_pkg;

    // Field order matches the control unit's 9-bit output, reg_dst in the MSB.
    typedef struct packed {
        logic reg_dst;
        logic branch;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_write;
        logic jump;
        logic word;
    } ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_MUL  = 6'h02;
    localparam logic [5:0] OP_LDB  = 6'h10;
    localparam logic [5:0] OP_LDW  = 6'h11;
    localparam logic [5:0] OP_STB  = 6'h12;
    localparam logic [5:0] OP_STW  = 6'h13;
    localparam logic [5:0] OP_BEQ  = 6'h30;
    localparam logic [5:0] OP_JUMP = 6'h31;

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [5:0]  opcode;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ex_bundle_t;

    function automatic logic uses_rs(input logic jump);
        return ~jump;
    endfunction

    // Stores read rt as write data even though the ALU takes the immediate.
    function automatic logic uses_rt(input logic jump, input logic alu_src,
                                     input logic mem_write);
        return (~alu_src | mem_write) & ~jump;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check between the execute-slot load and the decoding instruction.
module hazard_detect
    import proc_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_valid_i,
    input  logic       id_jump_i,
    input  logic       id_alu_src_i,
    input  logic       id_mem_write_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    output logic       hz_o
);

    logic rs_hit;
    logic rt_hit;
    logic load_in_ex;

    always_comb begin
        load_in_ex = ex_valid_i & ex_mem_read_i & id_valid_i;
        rs_hit = uses_rs(id_jump_i) & (id_rs_i == ex_rt_i) & (id_rs_i != REG_ZERO);
        rt_hit = uses_rt(id_jump_i, id_alu_src_i, id_mem_write_i)
               & (id_rt_i == ex_rt_i) & (id_rt_i != REG_ZERO);
        hz_o   = load_in_ex & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion, flush squash and
// saturating stall/flush event counters.
module id_ex_stage
    import proc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [8:0]       id_ctrl,
    input  logic [5:0]       id_opcode,
    input  logic [31:0]      id_pc4,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_flush,
    output logic             ex_valid,
    output logic [8:0]       ex_ctrl,
    output logic [5:0]       ex_opcode,
    output logic [31:0]      ex_pc4,
    output logic [31:0]      ex_rs_data,
    output logic [31:0]      ex_rt_data,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ex_bundle_t       ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    ctrl_t            id_ctrl_s;
    logic             hz;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign id_ctrl_s = ctrl_t'(id_ctrl);

    hazard_detect u_hazard_detect (
        .ex_valid_i     (ex_q.valid),
        .ex_mem_read_i  (ex_q.ctrl.mem_read),
        .ex_rt_i        (ex_q.rt),
        .id_valid_i     (id_valid),
        .id_jump_i      (id_ctrl_s.jump),
        .id_alu_src_i   (id_ctrl_s.alu_src),
        .id_mem_write_i (id_ctrl_s.mem_write),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .hz_o           (hz)
    );

    // A flush squashes the consumer anyway, so the stall it would have caused is dropped.
    assign stall = hz & ~ex_flush;

    always_comb begin
        ex_d        = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ex_flush) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (hz) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            ex_d.valid   = id_valid;
            ex_d.ctrl    = id_valid ? id_ctrl_s : '0;
            ex_d.opcode  = id_opcode;
            ex_d.pc4     = id_pc4;
            ex_d.rs_data = id_rs_data;
            ex_d.rt_data = id_rt_data;
            ex_d.imm     = id_imm;
            ex_d.rs      = id_rs;
            ex_d.rt      = id_rt;
            ex_d.rd      = id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_ctrl    = ex_q.ctrl;
    assign ex_opcode  = ex_q.opcode;
    assign ex_pc4     = ex_q.pc4;
    assign ex_rs_data = ex_q.rs_data;
    assign ex_rt_data = ex_q.rt_data;
    assign ex_imm     = ex_q.imm;
    assign ex_rs      = ex_q.rs;
    assign ex_rt      = ex_q.rt;
    assign ex_rd      = ex_q.rd;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each edge's EX contents.
module tb_id_ex_stage;
    import proc_pkg::*;

    localparam int unsigned CW = 4;

    // Control encodings, bit 8 = reg_dst ... bit 0 = word.
    localparam logic [8:0] C_ADD = 9'b1_0000_0100;
    localparam logic [8:0] C_LDW = 9'b0_0110_1101;
    localparam logic [8:0] C_STW = 9'b0_0001_1001;
    localparam logic [8:0] C_JMP = 9'b0_0000_0010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [8:0]    id_ctrl = '0;
    logic [5:0]    id_opcode = '0;
    logic [31:0]   id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [4:0]    id_rs = '0, id_rt = '0, id_rd = '0;
    logic          ex_flush = 1'b0;
    logic          ex_valid;
    logic [8:0]    ex_ctrl;
    logic [5:0]    ex_opcode;
    logic [31:0]   ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic          stall;
    logic [CW-1:0] stall_cnt, flush_cnt;

    id_ex_stage #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_ctrl    (id_ctrl),
        .id_opcode  (id_opcode),
        .id_pc4     (id_pc4),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .id_imm     (id_imm),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .ex_flush   (ex_flush),
        .ex_valid   (ex_valid),
        .ex_ctrl    (ex_ctrl),
        .ex_opcode  (ex_opcode),
        .ex_pc4     (ex_pc4),
        .ex_rs_data (ex_rs_data),
        .ex_rt_data (ex_rt_data),
        .ex_imm     (ex_imm),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .stall      (stall),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [8:0]    ctrl;
        logic [5:0]    opcode;
        logic [31:0]   pc4, rs_data, rt_data, imm;
        logic [4:0]    rs, rt, rd;
        logic [CW-1:0] scnt, fcnt;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m = '{valid: 1'b0, ctrl: '0, opcode: '0, pc4: '0, rs_data: '0, rt_data: '0,
              imm: '0, rs: '0, rt: '0, rd: '0, scnt: '0, fcnt: '0};
    endfunction

    function automatic logic model_hz();
        logic jmp, asrc, mw, u_rs, u_rt;
        jmp  = id_ctrl[1];
        asrc = id_ctrl[3];
        mw   = id_ctrl[4];
        u_rs = !jmp;
        u_rt = (!asrc || mw) && !jmp;
        return m.valid && m.ctrl[6] && id_valid &&
               ((u_rs && id_rs == m.rt && id_rs != 5'd0) ||
                (u_rt && id_rt == m.rt && id_rt != 5'd0));
    endfunction

    task automatic set_id(input logic v, input logic [8:0] c, input logic [5:0] op,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic fl);
        id_valid   = v;
        id_ctrl    = c;
        id_opcode  = op;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        ex_flush   = fl;
        id_pc4     = $urandom;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_imm     = $urandom;
    endtask

    // One clock: check stall mid-cycle, predict the edge, then compare after it.
    task automatic step();
        exp_t e;
        logic hz;
        @(negedge clk);
        hz = model_hz();
        check_eq("stall", {63'd0, stall}, {63'd0, hz && !ex_flush});
        e = m;
        if (ex_flush || hz) begin
            e.valid = 1'b0; e.ctrl = '0; e.opcode = '0; e.pc4 = '0; e.rs_data = '0;
            e.rt_data = '0; e.imm = '0; e.rs = '0; e.rt = '0; e.rd = '0;
            if (ex_flush) e.fcnt = (m.fcnt == '1) ? m.fcnt : m.fcnt + 1'b1;
            else          e.scnt = (m.scnt == '1) ? m.scnt : m.scnt + 1'b1;
        end else begin
            e.valid = id_valid; e.ctrl = id_valid ? id_ctrl : 9'd0; e.opcode = id_opcode;
            e.pc4 = id_pc4; e.rs_data = id_rs_data; e.rt_data = id_rt_data; e.imm = id_imm;
            e.rs = id_rs; e.rt = id_rt; e.rd = id_rd;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
        check_eq("ex_ctrl", {55'd0, ex_ctrl}, {55'd0, e.ctrl});
        check_eq("ex_opcode", {58'd0, ex_opcode}, {58'd0, e.opcode});
        check_eq("ex_data", {ex_pc4 ^ ex_rs_data, ex_rt_data ^ ex_imm},
                 {e.pc4 ^ e.rs_data, e.rt_data ^ e.imm});
        check_eq("ex_pc4", {32'd0, ex_pc4}, {32'd0, e.pc4});
        check_eq("ex_regs", {49'd0, ex_rs, ex_rt, ex_rd}, {49'd0, e.rs, e.rt, e.rd});
        check_eq("stall_cnt", {{(64-CW){1'b0}}, stall_cnt}, {{(64-CW){1'b0}}, e.scnt});
        check_eq("flush_cnt", {{(64-CW){1'b0}}, flush_cnt}, {{(64-CW){1'b0}}, e.fcnt});
        m = e;
    endtask

    task automatic load_use_pair(input logic [4:0] r);
        set_id(1'b1, C_LDW, OP_LDW, 5'd1, r, 5'd0, 1'b0); step();
        set_id(1'b1, C_ADD, OP_ADD, r, 5'd2, 5'd6, 1'b0); step(); step();
    endtask

    initial begin
        model_reset();
        #12;
        check_eq("reset_valid", {63'd0, ex_valid}, 64'd0);
        check_eq("reset_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load-use on rs: one bubble, then the ADD advances.
        set_id(1'b1, C_LDW, OP_LDW, 5'd1, 5'd3, 5'd0, 1'b0); step();
        set_id(1'b1, C_ADD, OP_ADD, 5'd3, 5'd4, 5'd5, 1'b0); step(); step();
        check_eq("rs_use_cnt", {60'd0, stall_cnt}, 64'd1);
        check_eq("rs_use_adv", {63'd0, ex_valid}, 64'd1);

        // Immediate-form rt read does not hazard; a store's rt does.
        set_id(1'b1, C_LDW, OP_LDW, 5'd1, 5'd3, 5'd0, 1'b0); step();
        set_id(1'b1, C_LDW, OP_LDW, 5'd5, 5'd3, 5'd0, 1'b0); step();
        set_id(1'b1, C_STW, OP_STW, 5'd5, 5'd3, 5'd0, 1'b0); step(); step();

        // r0 never hazards.
        set_id(1'b1, C_LDW, OP_LDW, 5'd1, 5'd0, 5'd0, 1'b0); step();
        set_id(1'b1, C_ADD, OP_ADD, 5'd0, 5'd0, 5'd7, 1'b0); step();

        // Flush coinciding with a hazard: flush wins.
        set_id(1'b1, C_LDW, OP_LDW, 5'd1, 5'd4, 5'd0, 1'b0); step();
        set_id(1'b1, C_ADD, OP_ADD, 5'd4, 5'd2, 5'd8, 1'b1); step();
        check_eq("flush_hz_fcnt", {60'd0, flush_cnt}, 64'd1);
        check_eq("flush_hz_scnt", {60'd0, stall_cnt}, 64'd2);

        // Jump ignores rs; an invalid slot never hazards and loads zero control.
        set_id(1'b1, C_LDW, OP_LDW, 5'd1, 5'd9, 5'd0, 1'b0); step();
        set_id(1'b1, C_JMP, OP_JUMP, 5'd9, 5'd9, 5'd0, 1'b0); step();
        set_id(1'b1, C_LDW, OP_LDW, 5'd1, 5'd9, 5'd0, 1'b0); step();
        set_id(1'b0, C_ADD, OP_ADD, 5'd9, 5'd9, 5'd1, 1'b0); step();

        // Bring both counters to 5, leave a valid instruction in EX, then reset mid-cycle.
        for (int i = 0; i < 3; i++) load_use_pair(5'd10 + 5'(i));
        for (int i = 0; i < 4; i++) begin
            set_id(1'b1, C_ADD, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b1); step();
        end
        set_id(1'b1, C_ADD, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0); step();
        check_eq("pre_rst_scnt", {60'd0, stall_cnt}, 64'd5);
        check_eq("pre_rst_fcnt", {60'd0, flush_cnt}, 64'd5);
        check_eq("pre_rst_valid", {63'd0, ex_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_valid", {63'd0, ex_valid}, 64'd0);
        check_eq("rst_async_ctrl", {55'd0, ex_ctrl}, 64'd0);
        check_eq("rst_async_cnts", {56'd0, stall_cnt, flush_cnt}, 64'd0);
        check_eq("rst_async_data", {ex_pc4, ex_imm}, 64'd0);
        check_eq("rst_async_stall", {63'd0, stall}, 64'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        set_id(1'b1, C_ADD, OP_SUB, 5'd1, 5'd2, 5'd3, 1'b0); step();

        // Saturation of both counters.
        for (int i = 0; i < 20; i++) load_use_pair(5'd1 + 5'(i % 30));
        check_eq("sat_scnt", {60'd0, stall_cnt}, 64'd15);
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, C_ADD, OP_MUL, 5'd1, 5'd2, 5'd3, 1'b1); step();
        end
        check_eq("sat_fcnt", {60'd0, flush_cnt}, 64'd15);
        load_use_pair(5'd20);
        check_eq("sat_scnt_hold", {60'd0, stall_cnt}, 64'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
